mem_addr_arbiter: RTL and testbench
===================================

Name: mem_addr_arbiter

Overview:
- Shares the single 8-bit memory address register between two requesters: instruction fetch (PC) and data access (load/store operand).
- Arbitrates round-robin and drives the address register's write-enable and input.
- Sequences a fixed-latency memory access, captures read data and returns a one-cycle acknowledge to the granted requester.
- Sits between the control unit / PC and the address register plus scratch-pad memory in the 8-bit RISC SPM.

Parameters:
- AW, 8, address width (matches address register).
- DW, 8, data width.
- MEM_LAT, 2, memory access cycles after the address is registered; legal range 1..15.

Ports:
- arb_clk  input  1  clock; all state changes on rising edge.
- arb_rst_n  input  1  synchronous, active-low reset.
- fetch_req  input  1  fetch request; held until fetch_ack.
- fetch_addr  input  AW  fetch address (PC).
- fetch_ack  output  1  one-cycle completion pulse for fetch.
- data_req  input  1  data request; held until data_ack.
- data_we  input  1  1 = store, 0 = load; sampled at grant.
- data_addr  input  AW  data address.
- data_wdata  input  DW  store data; sampled at grant.
- data_ack  output  1  one-cycle completion pulse for data.
- rdata  output  DW  last captured read data.
- addr_wr_en  output  1  write enable to the address register.
- addr_in  output  AW  address presented to the address register.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (arb_rst_n=0 at a rising edge):
  - state=IDLE; all outputs 0, including rdata.
  - last_grant=DATA, so fetch wins the first tie.
  - Latency counter cleared.
  - Reset mid-transaction aborts it: no ack is issued and mem_we drops the next cycle.
- FSM states: IDLE, LOAD, WAIT, DONE.
  - IDLE: if any req is high, grant and go to LOAD.
    - Only one request high: grant it.
    - Both high: grant the one not equal to last_grant.
    - On grant: latch the grant id and update last_grant. For data, also latch we and wdata. Fetch is always a read.
  - LOAD (1 cycle): addr_wr_en=1; addr_in = latched requester's address, sampled live from the granted port. Go to WAIT with counter=MEM_LAT-1.
  - WAIT (MEM_LAT cycles):
    - For a store: mem_we=1 and mem_wdata=latched wdata for every WAIT cycle.
    - For a load: on the final WAIT cycle (counter==0), capture mem_rdata into rdata.
    - When counter==0, go to DONE; otherwise decrement the counter.
  - DONE (1 cycle): pulse the granted ack; mem_we=0; go to IDLE.
- Outputs outside their defining states: addr_wr_en, mem_we and the acks are 0.
- addr_in is 0 outside LOAD.
- rdata holds its value until the next load completes; stores never modify rdata.
- Timing: req high in IDLE at cycle T gives LOAD at T+1, WAIT at T+2..T+1+MEM_LAT, and ack at T+2+MEM_LAT. Default: ack 4 cycles after req.
- Back-to-back: a new grant is possible in the IDLE cycle right after DONE, so minimum issue interval is MEM_LAT+3 cycles.
- A requester dropping req after grant does not cancel the transaction; the ack is still issued.
- If a req is still high in the IDLE cycle after its own ack, it is treated as a new request.
- Requests arriving while busy are held off (no ack) until arbitration in IDLE.
- Fairness: with both reqs continuously high, grants alternate F, D, F, D, ...

Decomposition:
- Shared package (spm_pkg):
  - State encoding constants ST_IDLE, ST_LOAD, ST_WAIT, ST_DONE.
  - Grant id constants GNT_FETCH=0, GNT_DATA=1.
  - AW/DW defaults.
- Natural sub-module: rr_arb2, a 2-input round-robin pick with a last_grant register, updated only on a grant strobe.
- FSM, latency counter and datapath latches stay in the top level.

Test Plan:
- Reset: hold arb_rst_n=0 for 2 cycles with both reqs high. Required: all outputs 0, busy=0. After release, fetch is granted first.
- Single fetch: fetch_addr=8'h10, mem_rdata=8'hA5, MEM_LAT=2, req at cycle T.
  - addr_wr_en=1 with addr_in=8'h10 at T+1.
  - fetch_ack=1 and rdata=8'hA5 at T+4.
  - data_ack stays 0.
- Store: data_req with data_we=1, data_addr=8'h3C, data_wdata=8'h5A.
  - mem_we=1 and mem_wdata=8'h5A for exactly 2 cycles (T+2, T+3).
  - data_ack at T+4.
  - rdata unchanged.
- Contention: both reqs held high for 20 cycles.
  - Grant order is F, D, F, D.
  - Acks spaced 5 cycles apart.
  - No two acks in the same cycle.
- Reset mid-WAIT: assert arb_rst_n=0 during a store's WAIT.
  - Next cycle: mem_we=0, state IDLE.
  - No ack is ever issued for the aborted transaction.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15 builds. Required: ack at T+3 and T+17 respectively.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared types and constants for the 8-bit RISC SPM memory path.
package spm_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/mem_addr_arbiter_if.sv
// Requester, address-register and scratch-pad signals of the arbiter.
interface mem_addr_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ack;
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_ack;
    logic [DW-1:0] rdata;
    logic          addr_wr_en;
    logic [AW-1:0] addr_in;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we,
        input  data_addr, data_wdata, mem_rdata,
        output fetch_ack, data_ack, rdata, addr_wr_en,
        output addr_in, mem_we, mem_wdata, busy
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we,
        output data_addr, data_wdata, mem_rdata,
        input  fetch_ack, data_ack, rdata, addr_wr_en,
        input  addr_in, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/mem_addr_arbiter_rr.sv
// Two-way round-robin pick; the last winner only moves on a grant strobe.
module rr_arb2
    import spm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       stb,
    output logic       gnt_id
);
    logic last;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= GNT_DATA;
        else if (stb)
            last <= gnt_id;
    end

    // req[0] is fetch, req[1] is data
    always_comb begin
        gnt_id = GNT_FETCH;
        unique case (req)
            2'b10:   gnt_id = GNT_DATA;
            2'b11:   gnt_id = ~last;
            default: gnt_id = GNT_FETCH;
        endcase
    end
endmodule

// File: rtl/mem_addr_arbiter.sv
// Shares the address register between fetch and data, sequencing
// a fixed-latency scratch-pad access per grant.
module mem_addr_arbiter
    import spm_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic         arb_clk,
    input  logic         arb_rst_n,
    mem_addr_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state;
    state_t           state_nx;
    logic             gnt_q;
    logic             we_q;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    rdata_q;
    logic [CNT_W-1:0] cnt;
    logic             pick;
    logic             stb;

    assign stb = (state == ST_IDLE)
               && (bus.fetch_req || bus.data_req);

    rr_arb2 u_arb (
        .clk    (arb_clk),
        .rst_n  (arb_rst_n),
        .req    ({bus.data_req, bus.fetch_req}),
        .stb    (stb),
        .gnt_id (pick)
    );

    always_ff @(posedge arb_clk) begin
        if (!arb_rst_n) begin
            state   <= ST_IDLE;
            gnt_q   <= GNT_FETCH;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (stb) begin
                gnt_q   <= pick;
                we_q    <= (pick == GNT_DATA) && bus.data_we;
                wdata_q <= bus.data_wdata;
            end
            if (state == ST_LOAD)
                cnt <= CNT_INIT;
            else if (state == ST_WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            // read data is valid on the last wait cycle only
            if (state == ST_WAIT && cnt == '0 && !we_q)
                rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nx       = state;
        bus.addr_wr_en = 1'b0;
        bus.addr_in    = '0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = '0;
        bus.fetch_ack  = 1'b0;
        bus.data_ack   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (stb)
                    state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                bus.addr_wr_en = 1'b1;
                bus.addr_in    = (gnt_q == GNT_DATA)
                               ? bus.data_addr
                               : bus.fetch_addr;
                state_nx       = ST_WAIT;
            end
            ST_WAIT: begin
                if (we_q) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = wdata_q;
                end
                if (cnt == '0)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                bus.fetch_ack = (gnt_q == GNT_FETCH);
                bus.data_ack  = (gnt_q == GNT_DATA);
                state_nx      = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Bench for mem_addr_arbiter: transaction-timeline model plus directed pins.
module tb_mem_addr_arbiter;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_addr_arbiter_if #(.AW(8), .DW(8)) b ();
    mem_addr_arbiter_if #(.AW(8), .DW(8)) i1 ();
    mem_addr_arbiter_if #(.AW(8), .DW(8)) i15 ();

    mem_addr_arbiter #(.AW(8), .DW(8), .MEM_LAT(LAT)) dut (
        .arb_clk   (clk),
        .arb_rst_n (rst_n),
        .bus       (b)
    );
    mem_addr_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) dut1 (
        .arb_clk   (clk),
        .arb_rst_n (rst_n),
        .bus       (i1)
    );
    mem_addr_arbiter #(.AW(8), .DW(8), .MEM_LAT(15)) dut15 (
        .arb_clk   (clk),
        .arb_rst_n (rst_n),
        .bus       (i15)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 0;

    // Model: position inside the current transaction, 0 when idle.
    // 1 = address phase, 2..LAT+1 = memory phase, LAT+2 = ack cycle.
    int       m_pos   = 0;
    bit       m_owner = 0;
    bit       m_last  = 1;
    bit       m_we    = 0;
    bit [7:0] m_wd    = 0;
    bit [7:0] m_rdata = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit f, d;
        f = b.fetch_req;
        d = b.data_req;
        if (!rst_n) begin
            m_pos   = 0;
            m_last  = 1;
            m_rdata = 0;
        end else if (m_pos == 0) begin
            if (f || d) begin
                m_owner = (f && d) ? !m_last : d;
                m_last  = m_owner;
                m_we    = m_owner && b.data_we;
                m_wd    = b.data_wdata;
                m_pos   = 1;
            end
        end else begin
            if (m_pos == LAT + 1 && !m_we)
                m_rdata = b.mem_rdata;
            m_pos = (m_pos == LAT + 2) ? 0 : m_pos + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            bit ld, wr, ak;
            logic [7:0] ea;
            ld = (m_pos == 1);
            wr = (m_pos >= 2 && m_pos <= LAT + 1 && m_we);
            ak = (m_pos == LAT + 2);
            ea = !ld ? 8'h00 :
                 m_owner ? b.data_addr : b.fetch_addr;
            chk("m_busy", b.busy, m_pos != 0);
            chk("m_addr_wr_en", b.addr_wr_en, ld);
            chk("m_addr_in", b.addr_in, ea);
            chk("m_mem_we", b.mem_we, wr);
            chk("m_mem_wdata", b.mem_wdata, wr ? m_wd : 8'h00);
            chk("m_fetch_ack", b.fetch_ack, ak && !m_owner);
            chk("m_data_ack", b.data_ack, ak && m_owner);
            chk("m_rdata", b.rdata, m_rdata);
        end
    end

    int ack_cyc[$];
    int ack_who[$];
    int both_cnt;
    int a1, a15, abort_acks;

    initial begin
        rst_n = 0;
        {i1.fetch_req, i1.data_req, i1.data_we} = '0;
        {i1.fetch_addr, i1.data_addr} = '0;
        {i1.data_wdata, i1.mem_rdata} = '0;
        {i15.fetch_req, i15.data_req, i15.data_we} = '0;
        {i15.fetch_addr, i15.data_addr} = '0;
        {i15.data_wdata, i15.mem_rdata} = '0;
        b.fetch_req  = 1;
        b.data_req   = 1;
        b.fetch_addr = 8'h10;
        b.data_addr  = 8'h3C;
        b.data_we    = 1;
        b.data_wdata = 8'h5A;
        b.mem_rdata  = 8'hA5;

        // reset with both requests pending
        tick();
        chk_on = 1;
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("reset_outs",
            {b.busy, b.addr_wr_en, b.addr_in, b.mem_we,
             b.mem_wdata, b.fetch_ack, b.data_ack, b.rdata},
            32'h0);

        // fetch wins the first tie, single fetch read
        tick();
        b.fetch_req = 0;
        @(negedge clk);
        chk("fetch_load", {b.addr_wr_en, b.addr_in}, {1'b1, 8'h10});
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("fetch_ack", {b.fetch_ack, b.data_ack}, 2'b10);
        chk("fetch_rdata", b.rdata, 8'hA5);

        // store follows in the next idle cycle
        tick();
        tick();
        b.data_req  = 0;
        b.mem_rdata = 8'h00;
        @(negedge clk);
        chk("store_load", {b.addr_wr_en, b.addr_in}, {1'b1, 8'h3C});
        tick();
        @(negedge clk);
        chk("store_we1", {b.mem_we, b.mem_wdata}, {1'b1, 8'h5A});
        tick();
        @(negedge clk);
        chk("store_we2", {b.mem_we, b.mem_wdata}, {1'b1, 8'h5A});
        tick();
        @(negedge clk);
        chk("store_ack", {b.data_ack, b.mem_we}, 2'b10);
        chk("store_rdata", b.rdata, 8'hA5);

        // contention: both held high for 20 cycles
        tick();
        b.fetch_req = 1;
        b.data_req  = 1;
        b.data_we   = 0;
        both_cnt    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b.fetch_ack && b.data_ack)
                both_cnt++;
            if (b.fetch_ack || b.data_ack) begin
                ack_cyc.push_back(i);
                ack_who.push_back(b.data_ack ? 1 : 0);
            end
            tick();
        end
        b.fetch_req = 0;
        b.data_req  = 0;
        chk("cont_both", both_cnt, 0);
        chk("cont_count", ack_cyc.size(), 4);
        for (int k = 0; k < ack_cyc.size(); k++) begin
            chk("cont_who", ack_who[k], k % 2);
            chk("cont_cycle", ack_cyc[k], 4 + 5 * k);
        end

        // reset during a store's wait phase
        b.data_req   = 1;
        b.data_we    = 1;
        b.data_addr  = 8'h55;
        b.data_wdata = 8'h77;
        tick();
        b.data_req = 0;
        tick();
        rst_n = 0;
        tick();
        @(negedge clk);
        chk("abort_idle", {b.mem_we, b.busy}, 2'b00);
        tick();
        rst_n = 1;
        abort_acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b.data_ack || b.fetch_ack)
                abort_acks++;
            tick();
        end
        chk("abort_noack", abort_acks, 0);

        // latency sweep on the MEM_LAT=1 and MEM_LAT=15 instances
        i1.fetch_req   = 1;
        i15.fetch_req  = 1;
        i1.fetch_addr  = 8'h21;
        i15.fetch_addr = 8'h22;
        a1  = -1;
        a15 = -1;
        for (int i = 0; i < 22; i++) begin
            if (i == 1) begin
                i1.fetch_req  = 0;
                i15.fetch_req = 0;
            end
            @(negedge clk);
            if (i1.fetch_ack && a1 < 0)
                a1 = i;
            if (i15.fetch_ack && a15 < 0)
                a15 = i;
            tick();
        end
        chk("lat1_ack", a1, 3);
        chk("lat15_ack", a15, 17);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            b.fetch_req  = ($urandom_range(0, 2) != 0);
            b.data_req   = ($urandom_range(0, 2) != 0);
            b.data_we    = $urandom_range(0, 1) == 1;
            b.fetch_addr = 8'($urandom);
            b.data_addr  = 8'($urandom);
            b.data_wdata = 8'($urandom);
            b.mem_rdata  = 8'($urandom);
            tick();
        end

        @(negedge clk);
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
